// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key event signals between scanner and its surroundings
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;

    modport master (input row_n, output col_n, output key_code, output key_valid);
    modport slave  (output row_n, input col_n, input key_code, input key_valid);
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with debounce, one event per press
module keypad_scanner #(
    parameter int SCAN_DIV        = 10_000,
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_scanner_if.master  kp
);
    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] DB_FULL    = BW'(DEBOUNCE_CYCLES);
    localparam logic [3:0]    NO_KEY     = 4'b1111;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

    state_t        state;
    logic [3:0]    sync1, sync2;
    logic [3:0]    pattern;
    logic [1:0]    col, row, low_row;
    logic [DW-1:0] dwell;
    logic [BW-1:0] db_cnt;
    logic [3:0]    key_code_q;
    logic          key_valid_q;

    // Rows 0-2 map to digits/letters; row 3 holds the control keys and 0.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = NO_KEY;
        if (c != 2'd3) begin
            if (r != 2'd3) code = 4'(r) * 4'd3 + 4'(c) + 4'd1;
            else begin
                case (c)
                    2'd0:    code = 4'b1101;
                    2'd1:    code = 4'b0000;
                    default: code = 4'b1110;
                endcase
            end
        end
        return code;
    endfunction

    always_comb begin
        low_row = 2'd0;
        if      (!sync2[0]) low_row = 2'd0;
        else if (!sync2[1]) low_row = 2'd1;
        else if (!sync2[2]) low_row = 2'd2;
        else if (!sync2[3]) low_row = 2'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= kp.row_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SCAN;
            col         <= 2'd0;
            row         <= 2'd0;
            pattern     <= 4'hF;
            dwell       <= '0;
            db_cnt      <= '0;
            key_code_q  <= NO_KEY;
            key_valid_q <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (&sync2) begin
                            col <= col + 2'd1;
                        end else begin
                            row     <= low_row;
                            pattern <= sync2;
                            db_cnt  <= '0;
                            state   <= DEBOUNCE;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (sync2 != pattern) begin
                        dwell <= '0;
                        state <= SCAN;
                    end else if (db_cnt == DB_LAST) begin
                        db_cnt      <= DB_FULL;
                        key_code_q  <= key_map(row, col);
                        key_valid_q <= (key_map(row, col) != NO_KEY);
                        state       <= EMIT;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    key_code_q  <= NO_KEY;
                    key_valid_q <= 1'b0;
                    db_cnt      <= '0;
                    state       <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    // Any low row means something is still held on this column.
                    if (!(&sync2)) begin
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        db_cnt <= '0;
                        dwell  <= '0;
                        col    <= col + 2'd1;
                        state  <= SCAN;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    assign kp.col_n     = ~(4'b0001 << col);
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a keypad matrix model
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DB       = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    // pressed[r*4+c] models the switch at row r, column c
    logic [15:0] pressed = '0;
    logic [3:0]  kmap [16];
    logic [3:0]  got_q [$];
    logic [3:0]  exp_q [$];
    int checks = 0;
    int errors = 0;

    always_comb begin
        kp.row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.col_n[c]) kp.row_n[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (kp.key_valid === 1'b1) got_q.push_back(kp.key_code);
            else check("idle_code", {28'd0, kp.key_code}, 32'hF);
            check("col_onehot", $countones(~kp.col_n), 1);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k, input int hold);
        pressed[k] = 1'b1;
        wait_cycles(hold);
        pressed[k] = 1'b0;
        wait_cycles(25);
        if (kmap[k] != 4'hF) exp_q.push_back(kmap[k]);
    endtask

    task automatic check_events(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_ev%0d", tag, i), {28'd0, got_q[i]}, {28'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        kmap = '{4'd1, 4'd2, 4'd3, 4'hF,
                 4'd4, 4'd5, 4'd6, 4'hF,
                 4'd7, 4'd8, 4'd9, 4'hF,
                 4'b1101, 4'b0000, 4'b1110, 4'hF};

        // reset state
        wait_cycles(3);
        check("rst_col", {28'd0, kp.col_n}, 32'hE);
        check("rst_code", {28'd0, kp.key_code}, 32'hF);
        check("rst_valid", {31'd0, kp.key_valid}, 0);
        rst_n = 1'b1;

        // clean '5' with latency measured from the start of column 1
        n = 0;
        while (kp.col_n !== 4'b1101 && n < 50) begin @(negedge clk); n++; end
        check("reach_col1", {31'd0, kp.col_n === 4'b1101}, 1);
        pressed[5] = 1'b1;
        n = 0;
        while (kp.key_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("lat5", n, (SCAN_DIV - 1) + DB + 1);
        check("lat5_code", {28'd0, kp.key_code}, 32'd5);
        @(negedge clk);
        check("lat5_onecycle", {31'd0, kp.key_valid}, 0);
        wait_cycles(40 - n - 1);
        pressed[5] = 1'b0;
        wait_cycles(25);
        exp_q.push_back(4'd5);
        check_events("clean5");

        // bouncy '#'
        pressed[14] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_cycles(3);
            pressed[14] = ~pressed[14];
        end
        check("bounce_quiet", got_q.size(), 0);
        press(14, 40);
        check_events("bounce_hash");

        // 1,2,3,4 then '*'
        press(0, 40); press(1, 40); press(2, 40); press(4, 40); press(12, 40);
        check_events("seq1234star");

        // A ignored, then 0
        press(3, 40); press(13, 40);
        check_events("a_then_0");

        // second key while first is held: only the first counts
        pressed[5] = 1'b1;
        wait_cycles(40);
        pressed[10] = 1'b1;
        wait_cycles(30);
        pressed[10] = 1'b0;
        wait_cycles(5);
        pressed[5] = 1'b0;
        wait_cycles(30);
        exp_q.push_back(4'd5);
        check_events("no_rollover");

        // reset during debounce of '7'
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        pressed[8] = 1'b1;
        wait_cycles(7);
        rst_n = 1'b0;
        #1;
        check("rst_mid_col", {28'd0, kp.col_n}, 32'hE);
        check("rst_mid_valid", {31'd0, kp.key_valid}, 0);
        wait_cycles(2);
        pressed[8] = 1'b0;
        rst_n = 1'b1;
        wait_cycles(30);
        check("rst_no_pulse", got_q.size(), 0);
        press(8, 40);
        check_events("rst_repress7");

        // rows 1 and 2 together on column 0
        pressed[4] = 1'b1;
        pressed[8] = 1'b1;
        wait_cycles(40);
        pressed[4] = 1'b0;
        wait_cycles(30);
        check("multirow_partial", got_q.size(), 1);
        pressed[8] = 1'b0;
        wait_cycles(25);
        exp_q.push_back(4'd4);
        check_events("multirow");

        // random keys and hold times
        for (int i = 0; i < 10; i++)
            press($urandom_range(0, 15), $urandom_range(40, 70));
        check_events("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 10_000: clock cycles each column is driven before its rows are sampled; legal range >= 2.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 100_000: consecutive stable synchronized samples required for a press or a release; legal range >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port row_n, input, 4 bits: keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 The block SHALL have port col_n, output, 4 bits: keypad column drive, active-low, exactly one bit low at all times.
REQ-007 The block SHALL have port key_code, output, 4 bits: lock-FSM key code; 4'b1111 when there is no event.
REQ-008 The block SHALL have port key_valid, output, 1 bit: high exactly in the cycle key_code carries an event.

Function
REQ-009 The block SHALL pass row_n through a 2-flop synchronizer; all row references below mean synchronized rows, and the synchronizer SHALL reset to 4'hF.
REQ-010 The key map SHALL be, for row r (0-3), column c (0-3): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = *,0,#,D.
REQ-011 The codes SHALL be: digits 1-9 -> 4'd1-4'd9; digit 0 -> 4'b0000; '#' (set passcode) -> 4'b1110; '*' (cancel) -> 4'b1101; A-D -> ignored, no event.
REQ-012 The FSM SHALL have states SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
REQ-013 SCAN SHALL drive column c low for SCAN_DIV cycles; on the last cycle it SHALL sample rows.
REQ-014 In SCAN, if all sampled rows are high, the column SHALL advance c -> c+1 mod 4 (3 -> 0) and the dwell count SHALL restart.
REQ-015 In SCAN, if any sampled row is low, the block SHALL latch c and the lowest-indexed low row (multi-row press: lowest index wins), latch the full row pattern, hold the column, and enter DEBOUNCE with count 0.
REQ-016 In DEBOUNCE, each cycle whose rows equal the latched pattern SHALL increment the count.
REQ-017 In DEBOUNCE, any mismatch SHALL return the FSM to SCAN on the same column with the dwell count restarted, emitting no event.
REQ-018 In DEBOUNCE, reaching DEBOUNCE_CYCLES matches SHALL cause a transition to EMIT.
REQ-019 EMIT SHALL last exactly one cycle: key_code = mapped code and key_valid = 1, both registered outputs, then WAIT_RELEASE.
REQ-020 For an ignored key (A-D), EMIT SHALL keep key_code = 4'b1111 and key_valid = 0.
REQ-021 Press latency SHALL be exactly DEBOUNCE_CYCLES+1 cycles from the SCAN sample cycle to the key_valid cycle.
REQ-022 In WAIT_RELEASE, the held column SHALL stay driven, and DEBOUNCE_CYCLES consecutive all-high row samples SHALL be required.
REQ-023 In WAIT_RELEASE, any low sample SHALL restart the release count.
REQ-024 On release completion, the FSM SHALL enter SCAN on column c+1 mod 4.
REQ-025 A held key SHALL produce exactly one event: no auto-repeat, and a second key pressed while the first is held SHALL be ignored until full release.
REQ-026 Outside EMIT, key_code SHALL be 4'b1111 and key_valid SHALL be 0 in every cycle.
REQ-027 Counter widths SHALL be $clog2(parameter+1); counters SHALL saturate and never wrap within a state.

Reset
REQ-028 While rst_n = 0, asynchronously: state = SCAN, column 0, col_n = 4'b1110, key_code = 4'b1111, key_valid = 0, all counters 0, synchronizer = 4'hF.
REQ-029 Reset asserted mid-DEBOUNCE, mid-EMIT or mid-WAIT_RELEASE SHALL abort the event with no key_valid pulse.
REQ-030 After deassertion, the FSM SHALL restart scanning from column 0 in the first clk edge.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-031 Clean press '5' (row1 low while col1 driven, held 40 cycles) -> exactly one cycle with key_code = 4'd5 and key_valid = 1, 9 cycles after the sample; key_code = 4'b1111 otherwise.
REQ-032 Bouncy press '#' (row3 toggling every 3 cycles for 20 cycles, then stable) -> no event during bounce; single 4'b1110 pulse after the stable window.
REQ-033 Sequence 1,2,3,4 with full releases, then '*' -> pulses 4'd1, 4'd2, 4'd3, 4'd4, 4'b1101 in order, one each, no others.
REQ-034 Key 'A' pressed and released, then '0' -> no event for A; a single 4'b0000 pulse with key_valid = 1 for 0.
REQ-035 rst_n low for 2 cycles during DEBOUNCE of '7' -> col_n = 4'b1110 immediately; no pulse; after release of rst_n, re-press '7' gives a single 4'd7 pulse.
REQ-036 Rows 1 and 2 low together on col0 -> single 4'd4 pulse (lowest row wins); no second pulse until both rows are released for 8 cycles.
